vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: display reads have absolute priority, and
// game accesses alternate with the clear/fill engine whenever they contend.
module vram_arbiter #(
  parameter int PIXELS = 76800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [18:0] disp_address,
  output logic        disp_valid,
  output logic [2:0]  disp_data,
  input  logic        game_req,
  input  logic        game_we,
  input  logic [18:0] game_address,
  input  logic [2:0]  game_wdata,
  output logic        game_ack,
  output logic        game_rvalid,
  output logic [2:0]  game_rdata,
  input  logic        fill_start,
  input  logic [2:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [18:0] ram_address,
  output logic        ram_write_enabled,
  output logic [2:0]  ram_write_data,
  input  logic [2:0]  ram_read_data
);

  localparam logic [18:0] PIX  = 19'(PIXELS);
  localparam logic [18:0] LAST = 19'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_GAME, OWN_FILL} owner_t;

  fill_state_t state;
  owner_t      owner;
  logic [18:0] counter;
  logic [2:0]  color;
  logic        last_fill;   // previous non-display grant went to the fill engine
  logic        rvalid_q;
  logic        rd_oob_q;
  logic        dvalid_q;
  logic        game_in_range;

  assign game_in_range = game_address < PIX;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    owner = OWN_NONE;
    if (reset)
      owner = OWN_NONE;
    else if (disp_req)
      owner = OWN_DISP;
    else if (game_req && (state != FILL || last_fill))
      owner = OWN_GAME;
    else if (state == FILL)
      owner = OWN_FILL;
  end

  always_comb begin
    ram_address       = '0;
    ram_write_enabled = 1'b0;
    ram_write_data    = '0;
    case (owner)
      OWN_DISP: ram_address = disp_address;
      OWN_GAME: begin
        ram_address       = game_address;
        ram_write_enabled = game_we && game_in_range;
        ram_write_data    = game_wdata;
      end
      OWN_FILL: begin
        ram_address       = counter;
        ram_write_enabled = 1'b1;
        ram_write_data    = color;
      end
      default: ;
    endcase
  end

  // Status and return paths are forced low for the whole reset window,
  // including the first reset cycle before the registers have cleared.
  assign game_ack    = (owner == OWN_GAME);
  assign fill_busy   = !reset && (state == FILL);
  assign fill_done   = !reset && (state == DONE);
  assign game_rvalid = !reset && rvalid_q;
  assign game_rdata  = (game_rvalid && !rd_oob_q) ? ram_read_data : 3'b000;
  assign disp_valid  = !reset && dvalid_q;
  assign disp_data   = disp_valid ? ram_read_data : 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      color     <= '0;
      last_fill <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_oob_q  <= 1'b0;
      dvalid_q  <= 1'b0;
    end else begin
      dvalid_q <= (owner == OWN_DISP);
      rvalid_q <= (owner == OWN_GAME) && !game_we;
      rd_oob_q <= !game_in_range;

      if (owner == OWN_GAME)
        last_fill <= 1'b0;
      else if (owner == OWN_FILL)
        last_fill <= 1'b1;

      case (state)
        IDLE: begin
          if (fill_start) begin
            color   <= fill_color;
            counter <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (owner == OWN_FILL) begin
            if (counter == LAST)
              state <= DONE;
            else
              counter <= counter + 19'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM
// (one-cycle read latency, out-of-range reads return 3'b111).
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [18:0] disp_address;
  logic        disp_valid;
  logic [2:0]  disp_data;
  logic        game_req;
  logic        game_we;
  logic [18:0] game_address;
  logic [2:0]  game_wdata;
  logic        game_ack;
  logic        game_rvalid;
  logic [2:0]  game_rdata;
  logic        fill_start;
  logic [2:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [18:0] ram_address;
  logic        ram_write_enabled;
  logic [2:0]  ram_write_data;
  logic [2:0]  ram_read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vram_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .disp_req          (disp_req),
    .disp_address      (disp_address),
    .disp_valid        (disp_valid),
    .disp_data         (disp_data),
    .game_req          (game_req),
    .game_we           (game_we),
    .game_address      (game_address),
    .game_wdata        (game_wdata),
    .game_ack          (game_ack),
    .game_rvalid       (game_rvalid),
    .game_rdata        (game_rdata),
    .fill_start        (fill_start),
    .fill_color        (fill_color),
    .fill_busy         (fill_busy),
    .fill_done         (fill_done),
    .ram_address       (ram_address),
    .ram_write_enabled (ram_write_enabled),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data)
  );

  logic [2:0] mem [0:76799];

  always @(posedge clock) begin
    if (ram_write_enabled && ram_address < 19'd76800)
      mem[ram_address] <= ram_write_data;
    ram_read_data <= (ram_address < 19'd76800) ? mem[ram_address] : 3'b111;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int  found;
    int  bad;
    int  busy_cycles;
    int  writes;
    int  errs;
    int  done_seen;

    reset = 1'b1; disp_req = 1'b0; disp_address = '0;
    game_req = 1'b1; game_we = 1'b1; game_address = 19'd5; game_wdata = 3'd6;
    fill_start = 1'b0; fill_color = '0;
    step(); step();
    check("rst_ack",    game_ack, 0);
    check("rst_we",     ram_write_enabled, 0);
    check("rst_busy",   fill_busy, 0);
    check("rst_done",   fill_done, 0);
    check("rst_rvalid", game_rvalid, 0);
    check("rst_dvalid", disp_valid, 0);
    check("rst_ddata",  disp_data, 0);
    check("rst_rdata",  game_rdata, 0);
    reset = 1'b0; game_req = 1'b0;
    #1;
    check("idle_addr",  ram_address, 0);
    check("idle_we",    ram_write_enabled, 0);
    check("idle_wdata", ram_write_data, 0);
    step();

    // Game write 3'b100 to 500, then read it back.
    game_req = 1'b1; game_we = 1'b1; game_address = 19'd500; game_wdata = 3'b100;
    #1;
    check("gw_ack",   game_ack, 1);
    check("gw_we",    ram_write_enabled, 1);
    check("gw_addr",  ram_address, 500);
    check("gw_wdata", ram_write_data, 3'b100);
    step();
    game_we = 1'b0;
    #1;
    check("gr_ack", game_ack, 1);
    check("gr_we",  ram_write_enabled, 0);
    step();
    game_req = 1'b0;
    #1;
    check("gr_rvalid", game_rvalid, 1);
    check("gr_rdata",  game_rdata, 3'b100);
    step();
    check("gr_rvalid_drop", game_rvalid, 0);

    // Out-of-range write is acked but suppressed; read returns 0.
    game_req = 1'b1; game_we = 1'b1; game_address = 19'd76800; game_wdata = 3'b111;
    #1;
    check("oob_w_ack", game_ack, 1);
    check("oob_w_we",  ram_write_enabled, 0);
    step();
    game_we = 1'b0;
    #1;
    check("oob_r_ack", game_ack, 1);
    step();
    game_req = 1'b0;
    #1;
    check("oob_rvalid", game_rvalid, 1);
    check("oob_rdata",  game_rdata, 0);
    step();

    // Display holds the bus; game waits until the first free cycle.
    disp_req = 1'b1; disp_address = 19'd500;
    game_req = 1'b1; game_we = 1'b1; game_address = 19'd10; game_wdata = 3'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("disp_block_ack",   game_ack, 0);
      check("disp_block_we",    ram_write_enabled, 0);
      check("disp_block_addr",  ram_address, 500);
      check("disp_block_wdata", ram_write_data, 0);
      if (i > 0) begin
        check("disp_valid", disp_valid, 1);
        check("disp_data",  disp_data, 3'b100);
      end
      step();
    end
    disp_req = 1'b0;
    #1;
    check("disp_release_ack", game_ack, 1);
    check("disp_last_valid",  disp_valid, 1);
    step();
    game_req = 1'b0;
    #1;
    check("disp_valid_drop", disp_valid, 0);
    step();

    // Fill start coincides with a game request: game wins, then alternation.
    game_req = 1'b1; game_we = 1'b1; game_address = 19'd200; game_wdata = 3'd1;
    fill_start = 1'b1; fill_color = 3'd5;
    #1;
    check("fs_game_wins", game_ack, 1);
    check("fs_not_busy",  fill_busy, 0);
    step();
    fill_start = 1'b0; fill_color = 3'd0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("alt_ack", game_ack, 32'(k % 2));
      if (k % 2 == 0) begin
        check("alt_fill_addr",  ram_address, 32'(k / 2));
        check("alt_fill_wdata", ram_write_data, 5);
      end
      step();
    end
    game_req = 1'b0;

    // Reset while the fill engine is about to write pixel 1000.
    found = 0;
    for (int n = 0; n < 2000; n++) begin
      #1;
      if (ram_write_enabled && ram_address == 19'd1000) begin
        found = 1;
        break;
      end
      step();
    end
    check("abort_reached", found, 1);
    reset = 1'b1;
    #1;
    check("abort_busy_rst", fill_busy, 0);
    check("abort_we_rst",   ram_write_enabled, 0);
    step();
    reset = 1'b0;
    #1;
    check("abort_busy", fill_busy, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (fill_done || ram_write_enabled) bad++;
      step();
    end
    check("abort_quiet", bad, 0);

    // A read acked just before reset must not return after reset.
    game_req = 1'b1; game_we = 1'b0; game_address = 19'd500;
    step();
    game_req = 1'b0; reset = 1'b1;
    #1;
    check("rd_rst_rvalid", game_rvalid, 0);
    step();
    reset = 1'b0;
    #1;
    check("rd_post_rst_rvalid", game_rvalid, 0);
    step();

    // Full fill with colour 0; a mid-fill fill_start with colour 7 is ignored.
    fill_start = 1'b1; fill_color = 3'd0;
    step();
    fill_start = 1'b0;
    busy_cycles = 0; writes = 0; errs = 0; done_seen = 0;
    for (int n = 0; n < 80000; n++) begin
      #1;
      if (fill_done) begin
        done_seen = 1;
        break;
      end
      if (fill_busy) busy_cycles++;
      if (ram_write_enabled) begin
        if (ram_address != 19'(writes) || ram_write_data != 3'd0) errs++;
        writes++;
      end
      fill_start = (n == 100);
      fill_color = (n == 100) ? 3'd7 : 3'd0;
      step();
    end
    check("fill_done_seen",   done_seen, 1);
    check("fill_busy_cycles", busy_cycles, 76800);
    check("fill_writes",      writes, 76800);
    check("fill_addr_errs",   errs, 0);
    check("fill_done_busy",   fill_busy, 0);
    step();
    check("fill_done_pulse", fill_done, 0);
    check("fill_idle_busy",  fill_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
